// File: rtl/arb_pkg.sv
// ----------------------------------------------------------------------------
// arb_pkg
//   Types and helper functions shared by the round-robin arbitration blocks.
//
//   Contents
//     ARB_MAX_W     widest request vector the helpers handle
//     arb_idx_t     requester index for the default 16-requester configuration
//     arb_vec_t     request/grant vector zero-extended to ARB_MAX_W
//     arb_cnt_t     population-count result (0 .. ARB_MAX_W)
//     popcount()    number of set bits in a vector
//     onehot2idx()  binary index of the set bit in a one-hot (or zero) vector
//
//   Callers zero-extend narrower vectors to arb_vec_t and truncate the result
//   of onehot2idx() to their own index width.
// ----------------------------------------------------------------------------
package arb_pkg;

   localparam int ARB_MAX_W     = 256;
   localparam int ARB_MAX_IDX_W = 8;
   localparam int ARB_CNT_W     = 9;

   localparam int ARB_DEF_WIDTH = 16;
   localparam int ARB_IDX_W     = $clog2(ARB_DEF_WIDTH);

   typedef logic [ARB_IDX_W-1:0] arb_idx_t;
   typedef logic [ARB_MAX_W-1:0] arb_vec_t;
   typedef logic [ARB_CNT_W-1:0] arb_cnt_t;

   function automatic arb_cnt_t popcount(input arb_vec_t v);
      arb_cnt_t c;
      c = '0;
      for (int i = 0; i < ARB_MAX_W; i++) begin
         c = c + arb_cnt_t'(v[i]);
      end
      return c;
   endfunction

   // OR-ing the indices of every set bit yields the exact index for a
   // one-hot input and zero for an all-zero input.
   function automatic logic [ARB_MAX_IDX_W-1:0] onehot2idx(input arb_vec_t v);
      logic [ARB_MAX_IDX_W-1:0] r;
      r = '0;
      for (int i = 0; i < ARB_MAX_W; i++) begin
         if (v[i]) begin
            r = r | ARB_MAX_IDX_W'(i);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_rot_sel.sv
// ----------------------------------------------------------------------------
// rr_rot_sel
//   Finds the first set request bit at or after a start index, wrapping
//   circularly. Two passes: the request vector masked to bits >= start is
//   searched first; if it is empty, the unmasked vector is searched, which
//   yields the first request below start (the wrapped part of the scan).
//
//   Ports
//     req    in   WIDTH   candidate request vector
//     start  in   IDX_W   index where the circular scan begins
//     sel    out  WIDTH   one-hot selected requester, zero when req is empty
//     found  out  1       a requester was selected
// ----------------------------------------------------------------------------
module rr_rot_sel #(
   parameter  int WIDTH = 16,
   localparam int IDX_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] req,
   input  logic [IDX_W-1:0] start,
   output logic [WIDTH-1:0] sel,
   output logic             found
);

   logic [WIDTH-1:0] hi_mask;
   logic [WIDTH-1:0] hi_req;
   logic [WIDTH-1:0] pick_src;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_mask
         assign hi_mask[gi] = (IDX_W'(gi) >= start);
      end
   endgenerate

   assign hi_req   = req & hi_mask;
   assign pick_src = (|hi_req) ? hi_req : req;

   // Isolate the lowest set bit of the chosen pass.
   assign sel   = pick_src & (~pick_src + WIDTH'(1));
   assign found = |req;

endmodule

// File: rtl/rr_multi_sel.sv
// ----------------------------------------------------------------------------
// rr_multi_sel
//   Round-robin multi-grant selector: up to REQS of WIDTH requesters are
//   granted per cycle, in circular order starting at a rotating pointer.
//   Grants are combinational (0-cycle) from req/avail/stall and the
//   registered pointer.
//
//   Parameters
//     WIDTH  number of requesters (>= 2, <= arb_pkg::ARB_MAX_W)
//     REQS   grant slots per cycle (1 .. WIDTH)
//     IDX_W  derived index width, do not override
//
//   Ports
//     clock        in   1            system clock
//     reset        in   1            synchronous, active-high
//     req          in   WIDTH        request vector
//     avail        in   REQS         slot k may accept a grant
//     stall        in   1            suppress all grants, freeze pointer
//     gnt          out  WIDTH        OR of all slot grants
//     gnt_bus      out  REQS*WIDTH   one-hot/zero grant, slot k at [k*WIDTH +: WIDTH]
//     gnt_idx      out  REQS*IDX_W   binary index of slot k's grant, 0 if invalid
//     gnt_valid    out  REQS         slot k carries a grant
//     empty        out  1            no requests at all
//     ptr          out  IDX_W        current highest-priority index
//
//   Optional build macro RR_MULTI_SEL_STATS_EN adds:
//     stat_grants  out  32   saturating total of grants issued
//     stat_denied  out  32   saturating count of cycles leaving requests unserved
// ----------------------------------------------------------------------------
module rr_multi_sel
   import arb_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int REQS  = 2,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [WIDTH-1:0]      req,
   input  logic [REQS-1:0]       avail,
   input  logic                  stall,
   output logic [WIDTH-1:0]      gnt,
   output logic [REQS*WIDTH-1:0] gnt_bus,
   output logic [REQS*IDX_W-1:0] gnt_idx,
   output logic [REQS-1:0]       gnt_valid,
   output logic                  empty,
   output logic [IDX_W-1:0]      ptr
`ifdef RR_MULTI_SEL_STATS_EN
   ,
   output logic [31:0]           stat_grants,
   output logic [31:0]           stat_denied
`endif
);

   logic [IDX_W-1:0] ptr_reg;
   logic [IDX_W-1:0] ptr_next;

   // Candidate m is the m-th requester in scan order (independent of avail).
   logic [WIDTH-1:0] cand_onehot [REQS];
   logic [REQS-1:0]  cand_found;
   // Scan position just after candidate m (where candidate m+1 search starts).
   logic [IDX_W-1:0] cand_after  [REQS];

   logic [WIDTH-1:0] slot_bus [REQS];
   logic [REQS-1:0]  slot_valid;
   arb_cnt_t         g_cnt;

   // ------------------------------------------------------------------------
   // Candidate chain: each stage removes the previous grant from the request
   // vector and restarts its scan one past it. Because every requester between
   // the pointer and the previous grant has already been taken, this yields
   // the requesters in circular scan order.
   // ------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < REQS; gi++) begin : g_stage
         logic [WIDTH-1:0] s_req;
         logic [IDX_W-1:0] s_start;
         logic [WIDTH-1:0] s_sel;
         logic             s_found;
         logic [IDX_W-1:0] s_idx;
         logic [IDX_W-1:0] s_after;

         if (gi == 0) begin : g_first
            assign s_req   = req;
            assign s_start = ptr_reg;
         end else begin : g_next
            assign s_req   = g_stage[gi-1].s_req & ~g_stage[gi-1].s_sel;
            assign s_start = g_stage[gi-1].s_after;
         end

         rr_rot_sel #(
            .WIDTH (WIDTH)
         ) u_rot_sel (
            .req   (s_req),
            .start (s_start),
            .sel   (s_sel),
            .found (s_found)
         );

         assign s_idx = IDX_W'(onehot2idx(arb_vec_t'(s_sel)));

         // Explicit wrap so non-power-of-two WIDTH never produces an
         // out-of-range index.
         assign s_after = !s_found ? s_start :
                          (s_idx == IDX_W'(WIDTH-1)) ? '0 : s_idx + IDX_W'(1);

         assign cand_onehot[gi] = s_sel;
         assign cand_found[gi]  = s_found;
         assign cand_after[gi]  = s_after;
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Slot compaction: the m-th available slot (ascending k) takes candidate m.
   // ------------------------------------------------------------------------
   always_comb begin
      int rank;
      for (int k = 0; k < REQS; k++) begin
         slot_bus[k]   = '0;
         slot_valid[k] = 1'b0;
      end
      rank = 0;
      for (int k = 0; k < REQS; k++) begin
         if (avail[k]) begin
            for (int m = 0; m < REQS; m++) begin
               if (m == rank) begin
                  slot_bus[k]   = cand_onehot[m];
                  slot_valid[k] = cand_found[m];
               end
            end
            rank = rank + 1;
         end
      end
   end

   // Grants issued this cycle ignoring stall: min(popcount(req), popcount(avail)).
   assign g_cnt = popcount(arb_vec_t'(slot_valid));

   generate
      for (gi = 0; gi < REQS; gi++) begin : g_slot
         assign gnt_bus[gi*WIDTH +: WIDTH] = stall ? '0 : slot_bus[gi];
         assign gnt_valid[gi]              = slot_valid[gi] & ~stall;
         assign gnt_idx[gi*IDX_W +: IDX_W] =
            IDX_W'(onehot2idx(arb_vec_t'(gnt_bus[gi*WIDTH +: WIDTH])));
      end
   endgenerate

   always_comb begin
      gnt = '0;
      for (int k = 0; k < REQS; k++) begin
         gnt = gnt | gnt_bus[k*WIDTH +: WIDTH];
      end
   end

   assign empty = ~|req;
   assign ptr   = ptr_reg;

   // ------------------------------------------------------------------------
   // Pointer: moves one past the last granted requester; holds on stall or
   // when nothing is granted.
   // ------------------------------------------------------------------------
   always_comb begin
      ptr_next = ptr_reg;
      if (!stall) begin
         for (int m = 1; m <= REQS; m++) begin
            if (arb_cnt_t'(m) == g_cnt) begin
               ptr_next = cand_after[m-1];
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ptr_reg <= '0;
      end else begin
         ptr_reg <= ptr_next;
      end
   end

`ifdef RR_MULTI_SEL_STATS_EN
   logic [31:0] stat_grants_reg;
   logic [31:0] stat_denied_reg;
   logic [32:0] grants_sum;
   logic        denied_hit;

   assign grants_sum = {1'b0, stat_grants_reg} + 33'(g_cnt);
   assign denied_hit = (popcount(arb_vec_t'(req)) > g_cnt);

   always_ff @(posedge clock) begin
      if (reset) begin
         stat_grants_reg <= '0;
         stat_denied_reg <= '0;
      end else if (!stall) begin
         stat_grants_reg <= grants_sum[32] ? '1 : grants_sum[31:0];
         if (denied_hit && (stat_denied_reg != '1)) begin
            stat_denied_reg <= stat_denied_reg + 32'd1;
         end
      end
   end

   assign stat_grants = stat_grants_reg;
   assign stat_denied = stat_denied_reg;
`endif

endmodule

// File: tb/tb_rr_multi_sel.sv
// ----------------------------------------------------------------------------
// tb_rr_multi_sel
//   Directed and randomized stimulus for rr_multi_sel (WIDTH=16, REQS=2).
//   The stimulus process computes each cycle's expected outputs from a
//   scan-order reference model and queues them; a monitor process pops and
//   compares on the falling edge. The monitor also tracks how long each
//   persistent requester waits. Build with RR_MULTI_SEL_STATS_EN defined to
//   also check the statistics counters.
// ----------------------------------------------------------------------------
module tb_rr_multi_sel;

   localparam int W     = 16;
   localparam int R     = 2;
   localparam int IW    = $clog2(W);
   localparam int BOUND = (W + R - 1) / R;
   localparam int NRAND = 10000;

   logic           clock;
   logic           reset;
   logic [W-1:0]   req;
   logic [R-1:0]   avail;
   logic           stall;
   logic [W-1:0]   gnt;
   logic [R*W-1:0] gnt_bus;
   logic [R*IW-1:0] gnt_idx;
   logic [R-1:0]   gnt_valid;
   logic           empty;
   logic [IW-1:0]  ptr;
`ifdef RR_MULTI_SEL_STATS_EN
   logic [31:0]    stat_grants;
   logic [31:0]    stat_denied;
`endif

   rr_multi_sel #(
      .WIDTH (W),
      .REQS  (R)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .req       (req),
      .avail     (avail),
      .stall     (stall),
      .gnt       (gnt),
      .gnt_bus   (gnt_bus),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .empty     (empty),
      .ptr       (ptr)
`ifdef RR_MULTI_SEL_STATS_EN
      ,
      .stat_grants (stat_grants),
      .stat_denied (stat_denied)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [W-1:0]    r;
      logic [R-1:0]    a;
      logic            s;
      logic            rs;
      logic [W-1:0]    gnt;
      logic [R*W-1:0]  bus;
      logic [R*IW-1:0] idx;
      logic [R-1:0]    vld;
      logic            empty;
      logic [IW-1:0]   ptr;
      int              g;
      logic [31:0]     sg;
      logic [31:0]     sd;
   } exp_t;

   exp_t exp_q[$];

   int  total_cnt;
   int  bad_cnt;
   bit  stim_done;

   // Reference model state
   int          m_ptr;
   logic [31:0] m_sg;
   logic [31:0] m_sd;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      total_cnt++;
      if (act !== expv) begin
         bad_cnt++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
      end
   endtask

   // Builds the requester list in circular scan order from p, then hands the
   // m-th entry to the m-th available slot.
   function automatic void model(input logic [W-1:0] r, input logic [R-1:0] a,
                                 input logic s, input int p,
                                 output exp_t e, output int np);
      int order[$];
      int m;
      e.r = r; e.a = a; e.s = s; e.rs = 1'b0;
      e.gnt = '0; e.bus = '0; e.idx = '0; e.vld = '0;
      e.empty = (r == '0);
      e.ptr = IW'(p);
      e.sg = '0; e.sd = '0;
      for (int st = 0; st < W; st++) begin
         int i;
         i = (p + st) % W;
         if (r[i]) order.push_back(i);
      end
      m = 0;
      for (int k = 0; k < R; k++) begin
         if (a[k] && (m < order.size())) begin
            logic [W-1:0] oh;
            oh = '0;
            oh[order[m]] = 1'b1;
            e.bus[k*W +: W]   = oh;
            e.idx[k*IW +: IW] = IW'(order[m]);
            e.vld[k]          = 1'b1;
            e.gnt             = e.gnt | oh;
            m++;
         end
      end
      e.g = m;
      np  = (m > 0) ? (order[m-1] + 1) % W : p;
      if (s) begin
         e.gnt = '0; e.bus = '0; e.idx = '0; e.vld = '0; e.g = 0;
      end
   endfunction

   task automatic step(input logic [W-1:0] r, input logic [R-1:0] a,
                       input logic s, input logic rs);
      exp_t e;
      int   np;
      int   g_raw;
      longint sum;
      @(posedge clock);
      #1;
      req = r; avail = a; stall = s; reset = rs;
      model(r, a, s, m_ptr, e, np);
      e.rs = rs;
      e.sg = m_sg;
      e.sd = m_sd;
      exp_q.push_back(e);
      g_raw = ($countones(r) < $countones(a)) ? $countones(r) : $countones(a);
      if (rs) begin
         m_ptr = 0; m_sg = '0; m_sd = '0;
      end else if (!s) begin
         m_ptr = np;
         sum = longint'(m_sg) + longint'(g_raw);
         m_sg = (sum > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(sum);
         if (($countones(r) > g_raw) && (m_sd != 32'hFFFF_FFFF)) m_sd = m_sd + 32'd1;
      end
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin : stim
      logic [W-1:0] r;
      logic [R-1:0] a;
      total_cnt = 0; bad_cnt = 0; stim_done = 0;
      m_ptr = 0; m_sg = '0; m_sd = '0;
      reset = 1'b1; req = '0; avail = '1; stall = 1'b0;
      repeat (3) @(posedge clock);

      // idle after reset
      step(16'h0000, 2'b11, 1'b0, 1'b0);
      step(16'h0000, 2'b11, 1'b0, 1'b0);
      // rotation across the top
      step(16'h8081, 2'b11, 1'b0, 1'b0);
      step(16'h8081, 2'b11, 1'b0, 1'b0);
      // reset back to 0, then only the upper slot available
      step(16'h0000, 2'b11, 1'b0, 1'b1);
      step(16'h0011, 2'b10, 1'b0, 1'b0);
      // move pointer to 14, then wrap
      step(16'h2000, 2'b11, 1'b0, 1'b0);
      step(16'hC003, 2'b11, 1'b0, 1'b0);
      step(16'h0000, 2'b11, 1'b0, 1'b0);
      // stall with everything requesting
      step(16'hFFFF, 2'b11, 1'b1, 1'b0);
      step(16'hFFFF, 2'b11, 1'b1, 1'b0);
      step(16'h0F00, 2'b11, 1'b0, 1'b0);
      // reset while grants are active
      step(16'hFFFF, 2'b11, 1'b0, 1'b1);
      step(16'hFFFF, 2'b11, 1'b0, 1'b0);
      step(16'hFFFF, 2'b11, 1'b0, 1'b0);

      r = W'($urandom);
      for (int c = 0; c < NRAND; c++) begin
         case ((c / 1000) % 3)
            0:       r = W'($urandom);
            1:       r = r ^ W'($urandom & $urandom & $urandom);
            default: r = W'($urandom | $urandom);
         endcase
         a = ($urandom_range(3) != 0) ? '1 : R'($urandom);
         step(r, a, ($urandom_range(7) == 0), ($urandom_range(511) == 0));
      end
      stim_done = 1;
   end

   // ----------------------------------------------------------------- monitor
   initial begin : mon
      exp_t e;
      int   wait_cnt [W];
      int   guard;
      for (int i = 0; i < W; i++) wait_cnt[i] = 0;
      guard = 0;
      while (1) begin
         @(negedge clock);
         guard++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            $display("txn t=%0t req=%h avail=%b stall=%b rst=%b ptr=%0d gnt=%h idx=%h vld=%b",
                     $time, e.r, e.a, e.s, e.rs, ptr, gnt, gnt_idx, gnt_valid);
            chk("gnt_bus",   64'(gnt_bus),   64'(e.bus));
            chk("gnt_idx",   64'(gnt_idx),   64'(e.idx));
            chk("gnt_valid", 64'(gnt_valid), 64'(e.vld));
            chk("gnt",       64'(gnt),       64'(e.gnt));
            chk("empty",     64'(empty),     64'(e.empty));
            chk("ptr",       64'(ptr),       64'(e.ptr));
            chk("grant_count", 64'($countones(gnt)), 64'(e.g));
`ifdef RR_MULTI_SEL_STATS_EN
            chk("stat_grants", 64'(stat_grants), 64'(e.sg));
            chk("stat_denied", 64'(stat_denied), 64'(e.sd));
`endif
            for (int i = 0; i < W; i++) begin
               if (e.r[i] && gnt[i]) begin
                  chk("starve_wait", 64'(wait_cnt[i] < BOUND), 64'(1));
                  wait_cnt[i] = 0;
               end else if (!e.r[i]) begin
                  wait_cnt[i] = 0;
               end else if (!e.s && (e.a == '1)) begin
                  wait_cnt[i]++;
               end
            end
            if (e.rs) begin
               for (int i = 0; i < W; i++) wait_cnt[i] = 0;
            end
         end
         if (stim_done && (exp_q.size() == 0)) break;
         if (guard > NRAND + 1000) begin
            total_cnt++;
            bad_cnt++;
            $display("FAIL timeout: got %0d monitor cycles, limit %0d", guard, NRAND + 1000);
            break;
         end
      end
      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
